gb_frame_sequencer: RTL

Generates the 512 Hz frame-sequencer timebase for the APU and decodes it into the one-cycle strobes the channel functions consume. `clk_length` (256 Hz), `clk_sweep` (128 Hz) and `clk_vol_env` (64 Hz) are produced here. `clk_vol_env` drives the envelope function of channels 1, 2 and 4 directly. The block sits upstream of every per-channel length, sweep and envelope unit, and is gated by the APU master enable (NR52 bit 7).

---
 rtl/gb_apu_pkg.sv | 31 +++
 rtl/gb_tick_divider.sv | 40 ++++
 rtl/gb_frame_sequencer.sv | 104 ++++++++++
 3 files changed

// File: rtl/gb_apu_pkg.sv
// gb_apu_pkg
// Shared APU constants and helpers. The frame-sequencer step decode lives
// here so that every consumer agrees on which step fires which strobe.
//   FS_STEPS       number of sequencer steps per frame
//   FS_STEP_ENV    step that clocks the volume envelopes
//   FS_LEN_MASK    bit n set -> step n clocks the length counters
//   FS_SWEEP_MASK  bit n set -> step n clocks the channel 1 sweep

package gb_apu_pkg;

    localparam int          FS_STEPS      = 8;
    localparam int          FS_STEP_W     = $clog2(FS_STEPS);
    localparam logic [2:0]  FS_STEP_ENV   = 3'd7;
    localparam logic [7:0]  FS_LEN_MASK   = 8'b0101_0101;
    localparam logic [7:0]  FS_SWEEP_MASK = 8'b0100_0100;

    typedef struct packed {
        logic len;
        logic sweep;
        logic env;
    } fs_strobe_t;

    function automatic fs_strobe_t fs_decode(input logic [FS_STEP_W-1:0] s);
        fs_strobe_t r;
        r.len   = FS_LEN_MASK[s];
        r.sweep = FS_SWEEP_MASK[s];
        r.env   = (s == FS_STEP_ENV);
        return r;
    endfunction

endpackage

// File: rtl/gb_tick_divider.sv
// gb_tick_divider
// Modulo-CLK_DIV prescaler: counts 0..CLK_DIV-1 while enabled and wraps to 0.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   clr    synchronous clear to 0 (dominates en)
//   en     count enable
//   wrap   high for the cycle in which the count equals CLK_DIV-1 and en=1

module gb_tick_divider #(
    parameter int CLK_DIV = 8192
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic wrap
);

    localparam int         W    = $clog2(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + W'(1);
            end
        end
    end

    assign wrap = en && !clr && (count == LAST);

endmodule

// File: rtl/gb_frame_sequencer.sv
// gb_frame_sequencer
// 512 Hz APU frame sequencer. Picks the tick source (internal prescaler or
// falling edge of an external DIV bit), advances an 8-step counter on each
// tick and registers one-cycle strobes for the length, sweep and envelope
// units.
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   apu_enable   APU master enable; 0 forces prescaler and step to 0
//   div_sel      0 = internal prescaler, 1 = falling edge of div_bit
//   div_bit      external DIV bit, synchronous to clk
//   frame_tick   one-cycle pulse per executed step
//   clk_length   one-cycle strobe on steps 0, 2, 4, 6
//   clk_sweep    one-cycle strobe on steps 2, 6
//   clk_vol_env  one-cycle strobe on step 7
//   step         step the next tick will execute
//
// step | meaning
// -----+----------------------
//  0   | length
//  1   | idle
//  2   | length + sweep
//  3   | idle
//  4   | length
//  5   | idle
//  6   | length + sweep
//  7   | volume envelope

module gb_frame_sequencer
    import gb_apu_pkg::*;
#(
    parameter int CLK_DIV = 8192
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 apu_enable,
    input  logic                 div_sel,
    input  logic                 div_bit,
    output logic                 frame_tick,
    output logic                 clk_length,
    output logic                 clk_sweep,
    output logic                 clk_vol_env,
    output logic [FS_STEP_W-1:0] step
);

    logic       div_bit_q;
    logic       presc_clr;
    logic       presc_en;
    logic       presc_wrap;
    logic       raw_tick;
    fs_strobe_t dec;

    // The prescaler is parked at 0 while powered off or in external mode,
    // so returning to internal mode always gives a full CLK_DIV period.
    assign presc_clr = !apu_enable || div_sel;
    assign presc_en  = apu_enable && !div_sel;

    gb_tick_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .en    (presc_en),
        .wrap  (presc_wrap)
    );

    // Sampled regardless of mode or power so a re-enable or a mode switch
    // sees a genuine previous value, never a stale one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_bit_q <= 1'b0;
        end else begin
            div_bit_q <= div_bit;
        end
    end

    assign raw_tick = div_sel ? (div_bit_q && !div_bit) : presc_wrap;
    assign dec      = fs_decode(step);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step        <= '0;
            frame_tick  <= 1'b0;
            clk_length  <= 1'b0;
            clk_sweep   <= 1'b0;
            clk_vol_env <= 1'b0;
        end else if (!apu_enable) begin
            step        <= '0;
            frame_tick  <= 1'b0;
            clk_length  <= 1'b0;
            clk_sweep   <= 1'b0;
            clk_vol_env <= 1'b0;
        end else begin
            frame_tick  <= raw_tick;
            clk_length  <= raw_tick && dec.len;
            clk_sweep   <= raw_tick && dec.sweep;
            clk_vol_env <= raw_tick && dec.env;
            if (raw_tick) begin
                step <= step + FS_STEP_W'(1);
            end
        end
    end

endmodule
